ula_mc: RTL and testbench



---
 rtl/ula_mc_if.sv | 14 +
 rtl/ula_mc.sv | 174 +++++++++++++++++
 tb/tb_ula_mc.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ula_mc_if.sv
// Request/result bundle for ula_mc: operands and opcode in, registered result and flags out.
interface ula_mc_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [3:0]       Op;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Res;
    logic             ResValid;
    logic [3:0]       FlagReg;

    modport master (output OpA, OpB, Op, InValid, input InReady, Res, ResValid, FlagReg);
    modport slave  (input OpA, OpB, Op, InValid, output InReady, Res, ResValid, FlagReg);
endinterface

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift, iterative MUL/DIVU/REMU.
// state | meaning
// IDLE  | accepting requests; single-cycle ops complete here
// BUSY  | iterating shift-add multiply or restoring divide, WIDTH steps
module ula_mc #(
    parameter int WIDTH = 16
) (
    input logic   CLK,
    input logic   RST,
    ula_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT            state;
    logic [WIDTH-1:0] resQ;
    logic [3:0]       flagQ;
    logic             validQ;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [3:0]       opReg;
    logic [SHW-1:0]   cnt;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   addWide;
    logic [WIDTH:0]   subWide;
    logic [WIDTH:0]   sllWide;
    logic [WIDTH:0]   srlWide;
    logic signed [WIDTH:0] sraWide;
    logic [WIDTH-1:0] scRes;
    logic             scC;
    logic             scV;
    logic             isMulti;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             ge;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic [WIDTH-1:0] finRes;
    logic             finV;

    assign bus.InReady  = (state == IDLE);
    assign bus.Res      = resQ;
    assign bus.FlagReg  = flagQ;
    assign bus.ResValid = validQ;

    assign isMulti = (bus.Op == OP_MUL) || (bus.Op == OP_DIVU) || (bus.Op == OP_REMU);

    // Shifts carry one extra guard bit so the last bit shifted out lands in a fixed position.
    always_comb begin
        amt     = bus.OpB[SHW-1:0];
        addWide = {1'b0, bus.OpA} + {1'b0, bus.OpB};
        subWide = {1'b0, bus.OpA} - {1'b0, bus.OpB};
        sllWide = {1'b0, bus.OpA} << amt;
        srlWide = {bus.OpA, 1'b0} >> amt;
        sraWide = $signed({bus.OpA, 1'b0}) >>> amt;
        scRes   = '0;
        scC     = 1'b0;
        scV     = 1'b0;
        case (bus.Op)
            OP_ADD: begin
                scRes = addWide[WIDTH-1:0];
                scC   = addWide[WIDTH];
                scV   = (bus.OpA[WIDTH-1] == bus.OpB[WIDTH-1]) && (addWide[WIDTH-1] != bus.OpA[WIDTH-1]);
            end
            OP_SUB: begin
                scRes = subWide[WIDTH-1:0];
                scC   = subWide[WIDTH];
                scV   = (bus.OpA[WIDTH-1] != bus.OpB[WIDTH-1]) && (subWide[WIDTH-1] != bus.OpA[WIDTH-1]);
            end
            OP_SLT: scRes = {{(WIDTH-1){1'b0}}, ($signed(bus.OpA) < $signed(bus.OpB))};
            OP_AND: scRes = bus.OpA & bus.OpB;
            OP_OR:  scRes = bus.OpA | bus.OpB;
            OP_XOR: scRes = bus.OpA ^ bus.OpB;
            OP_SLL: begin
                scRes = sllWide[WIDTH-1:0];
                scC   = sllWide[WIDTH];
            end
            OP_SRL: begin
                scRes = srlWide[WIDTH:1];
                scC   = srlWide[0];
            end
            OP_SRA: begin
                scRes = sraWide[WIDTH:1];
                scC   = sraWide[0];
            end
            default: scV = 1'b1;
        endcase
    end

    // One iteration of whichever long op is in flight; hi:lo is product or remainder:quotient.
    always_comb begin
        mulSum  = {1'b0, hi} + (lo[0] ? {1'b0, aReg} : '0);
        shifted = {hi, lo[WIDTH-1]};
        trial   = shifted[WIDTH-1:0] - bReg;
        ge      = (shifted >= {1'b0, bReg});
        if (opReg == OP_MUL) begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], lo[WIDTH-1:1]};
        end else begin
            stepHi = ge ? trial : shifted[WIDTH-1:0];
            stepLo = {lo[WIDTH-2:0], ge};
        end
        finRes = (opReg == OP_REMU) ? stepHi : stepLo;
        finV   = (opReg == OP_MUL) ? (stepHi != '0) : (bReg == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            resQ   <= '0;
            flagQ  <= '0;
            validQ <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            aReg   <= '0;
            bReg   <= '0;
            opReg  <= '0;
            cnt    <= '0;
        end else begin
            validQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.InValid) begin
                        if (isMulti) begin
                            state <= BUSY;
                            opReg <= bus.Op;
                            aReg  <= bus.OpA;
                            bReg  <= bus.OpB;
                            hi    <= '0;
                            lo    <= (bus.Op == OP_MUL) ? bus.OpB : bus.OpA;
                            cnt   <= SHW'(WIDTH - 1);
                        end else begin
                            resQ   <= scRes;
                            flagQ  <= {(scRes == '0), scRes[WIDTH-1], scC, scV};
                            validQ <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    hi <= stepHi;
                    lo <= stepLo;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        resQ   <= finRes;
                        flagQ  <= {(finRes == '0), finRes[WIDTH-1], 1'b0, finV};
                        validQ <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_mc.sv
// Bench for ula_mc at WIDTH=16 and WIDTH=32: directed vectors plus a cycle-level reference model.
module tb_ula_mc;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    ula_mc_if #(.WIDTH(16)) b16 ();
    ula_mc_if #(.WIDTH(32)) b32 ();

    ula_mc #(.WIDTH(16)) u16 (.CLK(CLK), .RST(RST), .bus(b16));
    ula_mc #(.WIDTH(32)) u32 (.CLK(CLK), .RST(RST), .bus(b32));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide-integer arithmetic masked to w bits.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] op, output logic [63:0] r, output logic [3:0] f);
        logic [63:0] mask, msb, aa, bb, s, p;
        longint sa, sb;
        int amt;
        logic c, v;
        mask = (64'd1 << w) - 64'd1;
        msb  = 64'd1 << (w - 1);
        aa   = a & mask;
        bb   = b & mask;
        sa   = ((aa & msb) != 0) ? longint'(aa) - longint'(64'd1 << w) : longint'(aa);
        sb   = ((bb & msb) != 0) ? longint'(bb) - longint'(64'd1 << w) : longint'(bb);
        amt  = int'(bb & 64'(w - 1));
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            4'd0: begin s = aa + bb; r = s & mask; c = ((s >> w) & 1) != 0;
                        v = ((aa ^ r) & (bb ^ r) & msb) != 0; end
            4'd1: begin r = (aa - bb) & mask; c = aa < bb; v = ((aa ^ bb) & (aa ^ r) & msb) != 0; end
            4'd2: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd3: r = aa & bb;
            4'd4: r = aa | bb;
            4'd5: r = aa ^ bb;
            4'd6: begin r = (aa << amt) & mask; c = (amt != 0) && (((aa >> (w - amt)) & 1) != 0); end
            4'd7: begin r = aa >> amt; c = (amt != 0) && (((aa >> (amt - 1)) & 1) != 0); end
            4'd8: begin r = 64'(sa >>> amt) & mask; c = (amt != 0) && (((aa >> (amt - 1)) & 1) != 0); end
            4'd9: begin p = aa * bb; r = p & mask; v = (p >> w) != 0; end
            4'd10: if (bb == 0) begin r = mask; v = 1'b1; end else r = aa / bb;
            4'd11: if (bb == 0) begin r = aa; v = 1'b1; end else r = aa % bb;
            default: begin r = '0; v = 1'b1; end
        endcase
        f = {(r == 0), ((r & msb) != 0), c, v};
    endfunction

    // Per-instance expected outputs after the most recent edge.
    int          mBusy [2];
    logic [63:0] mRes  [2];
    logic [63:0] mPend [2];
    logic [3:0]  mFlags[2];
    logic [3:0]  mPendF[2];
    bit          mValid[2];
    bit          known = 0;

    always @(negedge CLK) begin
        logic [63:0] res, a, b, r;
        logic [3:0]  fl, op, f;
        logic        rv, rdy, iv;
        int          w;
        string       tag;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                w = 16; tag = "w16";
                res = 64'(b16.Res); fl = b16.FlagReg; rv = b16.ResValid; rdy = b16.InReady;
                a = 64'(b16.OpA); b = 64'(b16.OpB); op = b16.Op; iv = b16.InValid;
            end else begin
                w = 32; tag = "w32";
                res = 64'(b32.Res); fl = b32.FlagReg; rv = b32.ResValid; rdy = b32.InReady;
                a = 64'(b32.OpA); b = 64'(b32.OpB); op = b32.Op; iv = b32.InValid;
            end
            if (known) begin
                check({tag, " ResValid"}, 64'(rv), 64'(mValid[i]));
                check({tag, " InReady"}, 64'(rdy), 64'(mBusy[i] == 0));
                check({tag, " Res"}, res, mRes[i]);
                check({tag, " FlagReg"}, 64'(fl), 64'(mFlags[i]));
            end
            if (RST) begin
                mBusy[i] = 0; mValid[i] = 1'b0; mRes[i] = '0; mFlags[i] = '0;
            end else if (mBusy[i] > 0) begin
                mBusy[i]--;
                mValid[i] = (mBusy[i] == 0);
                if (mBusy[i] == 0) begin mRes[i] = mPend[i]; mFlags[i] = mPendF[i]; end
            end else if (iv) begin
                model(w, a, b, op, r, f);
                if (op >= 4'd9 && op <= 4'd11) begin
                    mBusy[i] = w; mValid[i] = 1'b0; mPend[i] = r; mPendF[i] = f;
                end else begin
                    mValid[i] = 1'b1; mRes[i] = r; mFlags[i] = f;
                end
            end else begin
                mValid[i] = 1'b0;
            end
        end
        if (RST) known = 1;
    end

    task automatic drive(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic v);
        if (i == 0) begin
            b16.OpA = a[15:0]; b16.OpB = b[15:0]; b16.Op = op; b16.InValid = v;
        end else begin
            b32.OpA = a[31:0]; b32.OpB = b[31:0]; b32.Op = op; b32.InValid = v;
        end
    endtask

    task automatic sample(input int i, output logic rv, output logic rdy,
                          output logic [63:0] res, output logic [3:0] fl);
        if (i == 0) begin rv = b16.ResValid; rdy = b16.InReady; res = 64'(b16.Res); fl = b16.FlagReg; end
        else        begin rv = b32.ResValid; rdy = b32.InReady; res = 64'(b32.Res); fl = b32.FlagReg; end
    endtask

    // Called 2 time units after an edge; returns 2 units after the result edge so calls chain back-to-back.
    task automatic issue(input string name, input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [63:0] expR, input logic [3:0] expF,
                         input int expLat, input bit noise);
        logic rv, rdy;
        logic [63:0] res;
        logic [3:0] fl;
        int lat;
        drive(i, a, b, op, 1'b1);
        @(posedge CLK); #2;
        drive(i, a, b, op, 1'b0);
        lat = 0;
        sample(i, rv, rdy, res, fl);
        while (!rv && lat < 200) begin
            if (noise) drive(i, 64'h1, 64'h1, 4'd0, lat[0]);
            @(posedge CLK); #2;
            lat++;
            sample(i, rv, rdy, res, fl);
        end
        drive(i, a, b, op, 1'b0);
        check({name, " done"}, 64'(rv), 64'd1);
        check({name, " Res"}, res, expR);
        check({name, " FlagReg"}, 64'(fl), 64'(expF));
        check({name, " latency"}, 64'(lat), 64'(expLat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r, res;
        logic [3:0]  f, fl;
        logic        rv, rdy;
        RST = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 1'b0);

        model(16, 64'h7FFF, 64'h1, 4'd0, r, f);
        check("pin add16", {56'(r), f}, {56'h8000, 4'b0101});
        model(16, 64'd300, 64'd300, 4'd9, r, f);
        check("pin mul16", {56'(r), f}, {56'h5F90, 4'b0001});
        model(16, 64'h8001, 64'h1, 4'd8, r, f);
        check("pin sra16", {56'(r), f}, {56'hC000, 4'b0110});
        model(32, 64'h1234, 64'h0, 4'd11, r, f);
        check("pin remu0", {56'(r), f}, {56'h1234, 4'b0001});

        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        sample(0, rv, rdy, res, fl);
        check("reset Res", res, 64'd0);
        check("reset FlagReg", 64'(fl), 64'd0);
        check("reset InReady", 64'(rdy), 64'd1);
        check("reset ResValid", 64'(rv), 64'd0);

        issue("add ovf", 0, 64'h7FFF, 64'h0001, 4'd0, 64'h8000, 4'b0101, 0, 0);
        issue("sub borrow", 0, 64'h0000, 64'h0001, 4'd1, 64'hFFFF, 4'b0110, 0, 0);
        issue("slt", 0, 64'hFFFF, 64'h0001, 4'd2, 64'h0001, 4'b0000, 0, 0);
        issue("sra", 0, 64'h8001, 64'h0001, 4'd8, 64'hC000, 4'b0110, 0, 0);
        issue("add carry", 0, 64'hFFFF, 64'h0001, 4'd0, 64'h0000, 4'b1010, 0, 0);
        issue("sub ovf", 0, 64'h8000, 64'h0001, 4'd1, 64'h7FFF, 4'b0001, 0, 0);
        issue("and", 0, 64'hF0F0, 64'h0FF0, 4'd3, 64'h00F0, 4'b0000, 0, 0);
        issue("or", 0, 64'h8000, 64'h0001, 4'd4, 64'h8001, 4'b0100, 0, 0);
        issue("xor", 0, 64'hAAAA, 64'hAAAA, 4'd5, 64'h0000, 4'b1000, 0, 0);
        issue("sll", 0, 64'h8001, 64'h0001, 4'd6, 64'h0002, 4'b0010, 0, 0);
        issue("sll amt0", 0, 64'h1234, 64'h0010, 4'd6, 64'h1234, 4'b0000, 0, 0);
        issue("srl", 0, 64'h8001, 64'h0001, 4'd7, 64'h4000, 4'b0010, 0, 0);
        issue("mul 300sq", 0, 64'd300, 64'd300, 4'd9, 64'h5F90, 4'b0001, 16, 1);
        issue("mul small", 0, 64'd3, 64'd5, 4'd9, 64'h000F, 4'b0000, 16, 0);
        issue("mul max", 0, 64'hFFFF, 64'hFFFF, 4'd9, 64'h0001, 4'b0001, 16, 0);
        issue("divu", 0, 64'd100, 64'd7, 4'd10, 64'd14, 4'b0000, 16, 0);
        issue("remu", 0, 64'd100, 64'd7, 4'd11, 64'd2, 4'b0000, 16, 0);
        issue("divu by0", 0, 64'h1234, 64'h0, 4'd10, 64'hFFFF, 4'b0101, 16, 0);
        issue("remu by0", 0, 64'h1234, 64'h0, 4'd11, 64'h1234, 4'b0001, 16, 0);
        issue("illegal F", 0, 64'h1234, 64'h5678, 4'hF, 64'h0, 4'b1001, 0, 0);
        issue("illegal C", 0, 64'h0001, 64'h0001, 4'hC, 64'h0, 4'b1001, 0, 0);

        drive(0, 64'd300, 64'd300, 4'd9, 1'b1);
        @(posedge CLK); #2;
        drive(0, 64'd300, 64'd300, 4'd9, 1'b0);
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        @(posedge CLK);
        #2 RST = 1'b0;
        sample(0, rv, rdy, res, fl);
        check("abort Res", res, 64'd0);
        check("abort FlagReg", 64'(fl), 64'd0);
        check("abort InReady", 64'(rdy), 64'd1);
        check("abort ResValid", 64'(rv), 64'd0);
        repeat (20) @(posedge CLK);
        #2;
        issue("add after abort", 0, 64'd2, 64'd3, 4'd0, 64'd5, 4'b0000, 0, 0);

        issue("w32 add ovf", 1, 64'h7FFFFFFF, 64'h1, 4'd0, 64'h80000000, 4'b0101, 0, 0);
        issue("w32 slt", 1, 64'h1, 64'hFFFFFFFF, 4'd2, 64'h0, 4'b1000, 0, 0);
        issue("w32 sra", 1, 64'h80000001, 64'h1, 4'd8, 64'hC0000000, 4'b0110, 0, 0);
        issue("w32 mul", 1, 64'd300, 64'd300, 4'd9, 64'h00015F90, 4'b0000, 32, 1);
        issue("w32 divu", 1, 64'hFFFFFFFF, 64'h10, 4'd10, 64'h0FFFFFFF, 4'b0000, 32, 0);
        issue("w32 divu by0", 1, 64'h1234, 64'h0, 4'd10, 64'hFFFFFFFF, 4'b0101, 32, 0);
        issue("w32 illegal", 1, 64'h1, 64'h2, 4'hF, 64'h0, 4'b1001, 0, 0);

        repeat (3) @(posedge CLK);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
